// File: rtl/saradc_pkg.sv
// -----------------------------------------------------------------------------
// saradc_pkg
// Shared types and defaults for the SAR ADC controller slice.
//   state_e        : controller FSM state encoding (IDLE, SAMPLE, CONV, DONE)
//   NB_DEFAULT     : default conversion resolution in bits
//   NSAMP_DEFAULT  : default sample-phase length in clock cycles
//   CONV_PHASES    : clock cycles spent on each bit when the comparator
//                    synchroniser is built in (SARADC_SAR_CTRL_CMPSYNC_EN)
// -----------------------------------------------------------------------------
package saradc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SAMPLE = 2'd1,
      ST_CONV   = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam int NB_DEFAULT    = 8;
   localparam int NSAMP_DEFAULT = 4;

   // Trial code applied, two synchroniser stages, then capture.
   localparam int CONV_PHASES   = 3;

endpackage : saradc_pkg

// File: rtl/saradc_sar_ctrl_if.sv
// -----------------------------------------------------------------------------
// saradc_sar_ctrl_if
// Signal bundle between the SAR controller and its CDAC / comparator / user.
// Parameter NB sets the width of the per-bit switch buses and the result.
//   start        : conversion request (sampled only while idle)
//   cmp          : comparator decision, 1 = VIN at or above trial DAC level
//   cri / crib   : CDAC input-sample switch and complement
//   crh / crhb   : per-bit bottom-plate switch to VREFH and complement
//   crl / crlb   : per-bit bottom-plate switch to VREFL and complement
//   dout         : last conversion result, held until the next done
//   done         : one-cycle pulse when dout updates
//   busy         : high whenever the controller is not idle
//   state        : debug view of the controller FSM state
// Modports: slave = controller side, master = driver/observer side.
// Handshake: start is a level request with no ready; the controller samples
// it only in IDLE and ignores it everywhere else (no queueing). Completion
// is signalled by a single-cycle done with dout valid in that same cycle.
// -----------------------------------------------------------------------------
interface saradc_sar_ctrl_if
   import saradc_pkg::*;
#(
   parameter int NB = NB_DEFAULT
) ();

   logic          start;
   logic          cmp;
   logic          cri;
   logic          crib;
   logic [NB-1:0] crh;
   logic [NB-1:0] crhb;
   logic [NB-1:0] crl;
   logic [NB-1:0] crlb;
   logic [NB-1:0] dout;
   logic          done;
   logic          busy;
   state_e        state;

   modport slave (
      input  start, cmp,
      output cri, crib, crh, crhb, crl, crlb, dout, done, busy, state
   );

   modport master (
      output start, cmp,
      input  cri, crib, crh, crhb, crl, crlb, dout, done, busy, state
   );

endinterface : saradc_sar_ctrl_if

// File: rtl/saradc_cmp_sync.sv
// -----------------------------------------------------------------------------
// saradc_cmp_sync
// Two-flop synchroniser for the comparator decision. Only built when
// SARADC_SAR_CTRL_CMPSYNC_EN is defined.
//   clk  : clock
//   rst  : asynchronous active-high reset, both stages clear to 0
//   d_i  : asynchronous comparator output
//   q_o  : synchronised comparator decision (two cycles of latency)
// -----------------------------------------------------------------------------
module saradc_cmp_sync (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule : saradc_cmp_sync

// File: rtl/saradc_sar_ctrl.sv
// -----------------------------------------------------------------------------
// saradc_sar_ctrl
// Successive-approximation register controller for a charge-redistribution
// ADC. Samples the input onto the CDAC for NSAMP cycles, then resolves one bit
// per step from MSB to LSB using the comparator, and presents the result with
// a one-cycle done pulse.
// Parameters:
//   NB     : resolution in bits (2..16)
//   NSAMP  : sample-phase length in clock cycles (>= 1)
// Ports:
//   clk    : clock, all state on the rising edge
//   rst    : asynchronous active-high reset
//   bus    : saradc_sar_ctrl_if.slave (start/cmp in; switch controls,
//            dout, done, busy and debug state out)
// Build option:
//   SARADC_SAR_CTRL_CMPSYNC_EN : route cmp through saradc_cmp_sync; each bit
//   then takes CONV_PHASES cycles instead of one.
// All outputs come straight from flops; every complement is registered from
// the inverse of the same next-state value, so true/complement never skew.
// -----------------------------------------------------------------------------
module saradc_sar_ctrl
   import saradc_pkg::*;
#(
   parameter int NB    = NB_DEFAULT,
   parameter int NSAMP = NSAMP_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   saradc_sar_ctrl_if.slave  bus
);

   localparam int KW = (NB > 1) ? $clog2(NB) : 1;
   localparam int CW = $clog2(NSAMP + 1);

   // FSM and datapath state
   state_e        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [NB-1:0] code_q, code_d;      // resolved bits; unresolved bits are 0
   logic [CW-1:0] cnt_q, cnt_d;
   logic [NB-1:0] dout_q, dout_d;

   // Registered outputs
   logic          cri_q, cri_d, crib_q;
   logic [NB-1:0] crh_q, crh_d, crhb_q;
   logic [NB-1:0] crl_q, crl_d, crlb_q;
   logic          done_q, done_d;
   logic          busy_q, busy_d;

   logic [NB-1:0] trial;
   logic          cmp_use;
   logic          bit_end;

`ifdef SARADC_SAR_CTRL_CMPSYNC_EN
   logic [1:0]    ph_q, ph_d;

   saradc_cmp_sync u_cmp_sync (
      .clk (clk),
      .rst (rst),
      .d_i (bus.cmp),
      .q_o (cmp_use)
   );

   // The bit resolves on its last phase, when the synchroniser output
   // reflects the comparator's response to this bit's trial code.
   assign bit_end = (ph_q == 2'(CONV_PHASES - 1));
`else
   assign cmp_use = bus.cmp;
   assign bit_end = 1'b1;
`endif

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      code_d  = code_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
`ifdef SARADC_SAR_CTRL_CMPSYNC_EN
      ph_d    = ph_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_SAMPLE;
               cnt_d   = '0;
               code_d  = '0;
               k_d     = KW'(NB - 1);
            end
         end

         ST_SAMPLE: begin
            if (cnt_q == CW'(NSAMP - 1)) begin
               state_d = ST_CONV;
               k_d     = KW'(NB - 1);
`ifdef SARADC_SAR_CTRL_CMPSYNC_EN
               ph_d    = '0;
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         ST_CONV: begin
`ifdef SARADC_SAR_CTRL_CMPSYNC_EN
            ph_d = bit_end ? 2'd0 : (ph_q + 2'd1);
`endif
            if (bit_end) begin
               code_d[k_q] = cmp_use;
               if (k_q == '0) begin
                  state_d = ST_DONE;
               end else begin
                  k_d = k_q - KW'(1);
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            k_d     = KW'(NB - 1);
         end

         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_DONE) begin
         dout_d = code_d;
      end
   end

   // ---------------------------------------------------------------------
   // Output decode from the next state, so the flops hold the values that
   // belong to the state being entered.
   // ---------------------------------------------------------------------
   always_comb begin
      cri_d  = 1'b0;
      crh_d  = '0;
      crl_d  = '1;
      trial  = code_d | (NB'(1) << k_d);
      done_d = (state_d == ST_DONE);
      busy_d = (state_d != ST_IDLE);

      case (state_d)
         ST_SAMPLE: begin
            cri_d = 1'b1;
            crl_d = '0;
         end
         ST_CONV: begin
            crh_d = trial;
            crl_d = ~trial;
         end
         ST_DONE: begin
            crh_d = code_d;
            crl_d = ~code_d;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         k_q     <= KW'(NB - 1);
         code_q  <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
         cri_q   <= 1'b0;
         crib_q  <= 1'b1;
         crh_q   <= '0;
         crhb_q  <= '1;
         crl_q   <= '1;
         crlb_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef SARADC_SAR_CTRL_CMPSYNC_EN
         ph_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         cri_q   <= cri_d;
         crib_q  <= ~cri_d;
         crh_q   <= crh_d;
         crhb_q  <= ~crh_d;
         crl_q   <= crl_d;
         crlb_q  <= ~crl_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
`ifdef SARADC_SAR_CTRL_CMPSYNC_EN
         ph_q    <= ph_d;
`endif
      end
   end

   assign bus.cri   = cri_q;
   assign bus.crib  = crib_q;
   assign bus.crh   = crh_q;
   assign bus.crhb  = crhb_q;
   assign bus.crl   = crl_q;
   assign bus.crlb  = crlb_q;
   assign bus.dout  = dout_q;
   assign bus.done  = done_q;
   assign bus.busy  = busy_q;
   assign bus.state = state_q;

endmodule : saradc_sar_ctrl
